// File: rtl/mem_ref_datapath.sv
// mem_ref_datapath: Mano memory-reference datapath with request/ack handshake; define MEM_TIMEOUT_EN to abort stuck accesses.
module mem_ref_datapath #(
  parameter int DW = 16,
  parameter int AW = 12,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ctrl_valid,
  input  logic [16:0]   ctrl,
  output logic          stall,
  output logic [2:0]    opcode,
  output logic          ind,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [DW-1:0] ac_out,
  output logic [AW-1:0] pc_out,
  output logic          e_out,
  output logic          err
);
  typedef enum logic {IDLE, MEM_WAIT} state_t;
  state_t state, state_n;
  logic [14:0] ctrl_q, w;
  logic [AW-1:0] ar, pc, ar_n, pc_n;
  logic [DW-1:0] ir, dr, ac, ir_n, dr_n, ac_n;
  logic [DW:0] sum;
  logic e, e_n, idle, illegal, is_mem, ok, start, commit, timeout;
  logic unused_bits;
  function automatic logic multi(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction
  assign illegal = multi(ctrl[8:5]) | multi({1'b0, ctrl[2:0]}) | (ctrl[3] & ctrl[4])
                 | multi(ctrl[12:9]) | (ctrl[6] & ctrl[13]);
  assign is_mem = |ctrl[8:5];
  assign idle = state == IDLE;
  assign ok = ctrl_valid & !illegal;
  assign unused_bits = ^{ctrl[16:15], w[8:7]};
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign timeout = !idle && !mem_ack && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= idle ? '0 : cnt + 1'b1;
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    w = idle ? ctrl[14:0] : ctrl_q;
    start = idle & ok & is_mem;
    commit = idle ? ok & !is_mem : mem_ack;
    stall = idle ? start : !mem_ack & !timeout;
    state_n = idle ? (start ? MEM_WAIT : IDLE) : (mem_ack | timeout ? IDLE : MEM_WAIT);
  end
  always_comb begin
    sum = {1'b0, ac} + {1'b0, dr};
    ar_n = w[0] ? pc : w[1] ? ir[AW-1:0] : w[2] ? ar + 1'b1 : ar;
    pc_n = w[3] ? ar : w[4] ? pc + 1'b1 : pc;
    ir_n = w[5] ? mem_rdata : ir;
    dr_n = w[6] ? mem_rdata : w[13] ? '0 : dr;
    ac_n = w[9] ? ac & dr : w[10] ? sum[DW-1:0] : w[11] ? dr : w[12] ? '0 : ac;
    e_n = w[10] ? sum[DW] : w[14] ? 1'b0 : e;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      ctrl_q <= '0;
      ar <= '0;
      pc <= '0;
      ir <= '0;
      dr <= '0;
      ac <= '0;
      e <= 1'b0;
      err <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_n;
      if (commit) begin
        ar <= ar_n;
        pc <= pc_n;
        ir <= ir_n;
        dr <= dr_n;
        ac <= ac_n;
        e <= e_n;
      end
      if ((idle & ctrl_valid & illegal) | timeout) err <= 1'b1;
      if (start) begin
        ctrl_q <= ctrl[14:0];
        mem_req <= 1'b1;
        mem_addr <= ar;
        mem_we <= ctrl[7] | ctrl[8];
        mem_wdata <= ctrl[8] ? {{(DW-AW){1'b0}}, pc} : ac;
      end else if (!idle & (mem_ack | timeout)) mem_req <= 1'b0;
    end
  assign opcode = ir[DW-2:DW-4];
  assign ind = ir[DW-1];
  assign ac_out = ac;
  assign pc_out = pc;
  assign e_out = e;
endmodule
